// File: rtl/spi_p_slave.sv
// SPI mode-0 slave, LSB first, fully synchronous to clk.
// sclk/cs/mosi are oversampled through synchronizers and edge-detected in the clk domain.
module spi_p_slave #(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sclk,
  input  logic                 cs,
  input  logic                 mosi,
  output logic                 miso,
  input  logic [DATA_BITS-1:0] data_out,
  output logic [DATA_BITS-1:0] data_in,
  output logic                 busy,
  output logic                 done,
  output logic                 abort
);

  localparam int unsigned CNT_W  = $clog2(DATA_BITS + 1);
  localparam int unsigned FILL_W = $clog2(SYNC_STAGES + 2);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_BITS - 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(SYNC_STAGES + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_hist_q, cs_hist_q, mosi_hist_q;
  logic [FILL_W-1:0]      fill_q;
  logic                   armed_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [DATA_BITS-1:0]   tx_q, rx_q;

  logic sclk_s, cs_s;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [DATA_BITS-1:0] rx_next;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hist_q;
  assign sclk_fall = ~sclk_s & sclk_hist_q;
  assign cs_rise   = cs_s & ~cs_hist_q;
  assign cs_fall   = ~cs_s & cs_hist_q;
  // mosi taken from the history stage: the value held just before the sclk edge
  assign rx_next   = rx_q | (DATA_BITS'(mosi_hist_q) << cnt_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_hist_q <= 1'b0;
      cs_hist_q   <= 1'b0;
      mosi_hist_q <= 1'b0;
      fill_q      <= '0;
      armed_q     <= 1'b0;
      cnt_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      miso        <= 1'b0;
      data_in     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      abort       <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sclk_hist_q <= sclk_s;
      cs_hist_q   <= cs_s;
      mosi_hist_q <= mosi_sync_q[SYNC_STAGES-1];
      done        <= 1'b0;
      abort       <= 1'b0;

      // A start needs cs seen low once the pipeline holds real post-reset samples
      if (fill_q != FILL_MAX) begin
        fill_q <= fill_q + FILL_W'(1);
      end else if (!cs_s) begin
        armed_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          miso <= 1'b0;
          if (cs_rise && armed_q) begin
            state_q <= SHIFT;
            tx_q    <= data_out;
            rx_q    <= '0;
            cnt_q   <= '0;
            busy    <= 1'b1;
            miso    <= data_out[0];
          end
        end
        SHIFT: begin
          if (cs_fall) begin
            // cs loss wins even against a coincident final sclk rise
            state_q <= IDLE;
            busy    <= 1'b0;
            abort   <= 1'b1;
            miso    <= 1'b0;
            cnt_q   <= '0;
          end else if (sclk_rise) begin
            rx_q  <= rx_next;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BIT) begin
              state_q <= HOLD;
              data_in <= rx_next;
              done    <= 1'b1;
              miso    <= 1'b0;
            end
          end else if (sclk_fall) begin
            tx_q <= tx_q >> 1;
            miso <= tx_q[1];
          end
        end
        HOLD: begin
          miso <= 1'b0;
          if (cs_fall) begin
            state_q <= IDLE;
            busy    <= 1'b0;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
          miso    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/spi_p_slave.md
SPI_P_SLAVE -- requirements
Module: spi_p_slave

Interface
REQ-001 Parameter DATA_BITS, default 8, word length in bits (2..15).
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer depth for sclk/cs/mosi (>=2).
REQ-003 clk  input  1  single system clock; all logic on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 sclk  input  1  serial clock from master; idles low.
REQ-006 cs  input  1  chip select from master, active-high.
REQ-007 mosi  input  1  serial data from master.
REQ-008 miso  output  1  serial data to master.
REQ-009 data_out  input  DATA_BITS  word to transmit; captured at transfer start.
REQ-010 data_in  output  DATA_BITS  last fully received word.
REQ-011 busy  output  1  high while a transfer is in progress.
REQ-012 done  output  1  one-clk pulse when a full word has been received.
REQ-013 abort  output  1  one-clk pulse when cs drops before DATA_BITS bits are received.

Function
REQ-014 sclk, cs, mosi SHALL each pass through SYNC_STAGES flops plus one history flop; edges are detected only on synchronized values.
REQ-015 Protocol: mode 0, LSB first; slave samples mosi on sclk rising edge, updates miso on sclk falling edge.
REQ-016 States: IDLE, SHIFT, HOLD.
REQ-017 IDLE -> SHIFT on synchronized cs rising edge; same cycle: tx shift register <= data_out, bit counter <= 0, busy <= 1.
REQ-018 In SHIFT, miso SHALL drive tx register bit 0 starting the cycle after cs rising edge detection.
REQ-019 In SHIFT, on each synchronized sclk rising edge, rx shift register bit[counter] <= synchronized mosi and counter += 1.
REQ-020 In SHIFT, on each synchronized sclk falling edge, tx register shifts right by one (zero fill); miso follows new bit 0.
REQ-021 When the DATA_BITS-th rising edge is sampled: data_in <= complete rx word (including that bit) the next cycle, done pulses for exactly one cycle coincident with data_in update, state -> HOLD.
REQ-022 HOLD: further sclk edges ignored, miso = 0, busy stays 1; synchronized cs falling edge -> IDLE, busy <= 0, no abort.
REQ-023 Synchronized cs falling edge in SHIFT -> IDLE, abort pulses one cycle, data_in unchanged, done not asserted.
REQ-024 Simultaneous cs falling edge and final sclk rising edge in one cycle: cs wins; treated as abort.
REQ-025 cs low: miso = 0 and sclk/mosi activity ignored.
REQ-026 done and abort SHALL never be high in the same cycle.
REQ-027 Counter width $clog2(DATA_BITS+1); it SHALL never exceed DATA_BITS.
REQ-028 Correct operation requires each sclk high and low phase >= SYNC_STAGES+2 clk cycles and cs assertion >= SYNC_STAGES+2 clk cycles before first sclk rise.
REQ-029 data_out changes after transfer start SHALL NOT affect the word in flight.

Reset
REQ-030 On reset high at posedge clk: state IDLE, miso 0, data_in 0, busy 0, done 0, abort 0, counter 0, shift registers 0, synchronizer/history flops 0.
REQ-031 Reset asserted mid-transfer SHALL discard the transfer with no done or abort pulse; after release a new cs rising edge is required to start.
REQ-032 If cs is high when reset releases, no transfer starts until cs goes low then high.

Verification
REQ-033 DATA_BITS=8, data_out=8'hA5, master sends mosi 8'h3C LSB first, sclk half-period 6 clk -> miso bits 1,0,1,0,0,1,0,1; data_in=8'h3C; one done pulse.
REQ-034 Back-to-back words 8'h01 then 8'hFE with cs dropped 10 clk between -> two done pulses, data_in 8'h01 then 8'hFE, busy low between.
REQ-035 cs dropped after 5 sclk rising edges -> one abort pulse, no done, data_in retains previous value.
REQ-036 12 sclk cycles within one cs window, mosi word 8'h81 -> done once after 8th rise, data_in=8'h81, extra edges ignored, miso 0 in HOLD.
REQ-037 Reset pulsed after 3 bits, then full transfer of 8'h55 -> no done/abort from first, done with data_in=8'h55 from second.
REQ-038 data_out changed from 8'hF0 to 8'h0F after cs rise -> miso shows 8'hF0 LSB first.
